// File: rtl/sd_pkg.sv
// Shared definitions for the sphere-decoder metric selection stage:
// the FSM state encoding, the default metric width and the all-ones
// "no candidate" metric.
package sd_pkg;

    localparam int METRIC_W_DEFAULT = 32;

    localparam logic [METRIC_W_DEFAULT-1:0] METRIC_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/metric_min_select_if.sv
// Stream bundle between the metric stage, metric_min_select and the
// tree-search control. The slave modport is the selector's view; the
// master modport is the environment's view (metric source + result sink).
//
// Handshake: a beat moves when in_valid && in_ready are both high at a
// rising edge; a result moves when out_valid && out_ready are both high.
// A source holds its payload stable while valid is high and ready is low.
//
// Optional macro METRIC_MIN_SECOND_EN adds out_metric2/out_idx2.
interface metric_min_select_if #(
    parameter int WIDTH    = 32,
    parameter int NUM_CAND = 16
);
    import sd_pkg::*;

    localparam int IDX_W = $clog2(NUM_CAND);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_metric;
    logic [WIDTH-1:0] radius;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_metric;
    logic [IDX_W-1:0] out_idx;
    logic             out_found;
`ifdef METRIC_MIN_SECOND_EN
    logic [WIDTH-1:0] out_metric2;
    logic [IDX_W-1:0] out_idx2;
`endif
    state_t           dbg_state;

`ifdef METRIC_MIN_SECOND_EN
    modport slave (
        input  in_valid, in_metric, radius, out_ready,
        output in_ready, out_valid, out_metric, out_idx, out_found,
               out_metric2, out_idx2, dbg_state
    );
    modport master (
        output in_valid, in_metric, radius, out_ready,
        input  in_ready, out_valid, out_metric, out_idx, out_found,
               out_metric2, out_idx2, dbg_state
    );
`else
    modport slave (
        input  in_valid, in_metric, radius, out_ready,
        output in_ready, out_valid, out_metric, out_idx, out_found,
               dbg_state
    );
    modport master (
        output in_valid, in_metric, radius, out_ready,
        input  in_ready, out_valid, out_metric, out_idx, out_found,
               dbg_state
    );
`endif

endinterface

// File: rtl/metric_min_select_min_cmp_update.sv
// Combinational running-minimum update for one candidate metric.
// A metric qualifies only when strictly below the radius; it replaces the
// best only when strictly smaller, so earlier arrivals win ties.
// With METRIC_MIN_SECOND_EN the runner-up is tracked as well.
module min_cmp_update #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 4
) (
    input  logic [WIDTH-1:0] best,
    input  logic [IDX_W-1:0] best_idx,
    input  logic             found,
`ifdef METRIC_MIN_SECOND_EN
    input  logic [WIDTH-1:0] second,
    input  logic [IDX_W-1:0] second_idx,
    output logic [WIDTH-1:0] nxt_second,
    output logic [IDX_W-1:0] nxt_second_idx,
`endif
    input  logic [WIDTH-1:0] metric,
    input  logic [IDX_W-1:0] idx,
    input  logic [WIDTH-1:0] rad,
    output logic [WIDTH-1:0] nxt_best,
    output logic [IDX_W-1:0] nxt_best_idx,
    output logic             nxt_found,
    output logic             qualify
);

    // Qualify against the radius, then fold into best (and second).
    always_comb begin
        qualify      = (metric < rad);
        nxt_best     = best;
        nxt_best_idx = best_idx;
        nxt_found    = found;
`ifdef METRIC_MIN_SECOND_EN
        nxt_second     = second;
        nxt_second_idx = second_idx;
`endif
        if (qualify) begin
            nxt_found = 1'b1;
            if (metric < best) begin
                nxt_best     = metric;
                nxt_best_idx = idx;
`ifdef METRIC_MIN_SECOND_EN
                // The displaced minimum becomes the runner-up.
                nxt_second     = best;
                nxt_second_idx = best_idx;
`endif
            end
`ifdef METRIC_MIN_SECOND_EN
            else if (metric < second) begin
                nxt_second     = metric;
                nxt_second_idx = idx;
            end
`endif
        end
    end

endmodule

// File: rtl/metric_min_select.sv
// Sphere-decoder minimum selector: consumes NUM_CAND L1 metrics per group,
// keeps the smallest one strictly inside the radius sampled on the group's
// first beat, and presents metric/index/found until the consumer accepts.
// Optional macro METRIC_MIN_SECOND_EN also reports the second-smallest
// qualifying metric for soft-output LLR computation.
module metric_min_select
    import sd_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NUM_CAND = 16
) (
    input  logic                clk,
    input  logic                rst,
    metric_min_select_if.slave  bus
);

    localparam int               IDX_W    = $clog2(NUM_CAND);
    localparam logic [WIDTH-1:0] BEST_INIT = '1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CAND - 1);

    state_t           state;
    state_t           state_nxt;
    logic             in_ready_c;
    logic             out_valid_c;
    logic             accept;
    logic             last_beat;

    logic [IDX_W-1:0] count;
    logic [WIDTH-1:0] rad_q;
    logic [WIDTH-1:0] cmp_rad;
    logic [WIDTH-1:0] best;
    logic [IDX_W-1:0] best_idx;
    logic             found;
    logic [WIDTH-1:0] nxt_best;
    logic [IDX_W-1:0] nxt_best_idx;
    logic             nxt_found;
    logic             qualify;
`ifdef METRIC_MIN_SECOND_EN
    logic [WIDTH-1:0] second;
    logic [IDX_W-1:0] second_idx;
    logic [WIDTH-1:0] nxt_second;
    logic [IDX_W-1:0] nxt_second_idx;
`endif

    assign accept    = bus.in_valid && in_ready_c;
    assign last_beat = accept && (count == LAST_IDX);

    // The first beat of a group is judged against the live radius input,
    // since rad_q only captures it on that same edge.
    assign cmp_rad = (state == IDLE) ? bus.radius : rad_q;

    min_cmp_update #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_cmp (
        .best           (best),
        .best_idx       (best_idx),
        .found          (found),
`ifdef METRIC_MIN_SECOND_EN
        .second         (second),
        .second_idx     (second_idx),
        .nxt_second     (nxt_second),
        .nxt_second_idx (nxt_second_idx),
`endif
        .metric         (bus.in_metric),
        .idx            (count),
        .rad            (cmp_rad),
        .nxt_best       (nxt_best),
        .nxt_best_idx   (nxt_best_idx),
        .nxt_found      (nxt_found),
        .qualify        (qualify)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; in_ready is low throughout HOLD,
    // including the cycle in which the result is accepted.
    always_comb begin
        state_nxt   = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                in_ready_c = 1'b1;
                if (bus.in_valid && (count == LAST_IDX)) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Accumulate the running minimum; re-initialise once the result leaves
    // so the next group never sees a stale best.
    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            rad_q    <= '0;
            best     <= BEST_INIT;
            best_idx <= '0;
            found    <= 1'b0;
`ifdef METRIC_MIN_SECOND_EN
            second     <= BEST_INIT;
            second_idx <= '0;
`endif
        end else begin
            if (accept) begin
                if (state == IDLE) begin
                    rad_q <= bus.radius;
                end
                count    <= last_beat ? '0 : count + IDX_W'(1);
                best     <= nxt_best;
                best_idx <= nxt_best_idx;
                found    <= nxt_found;
`ifdef METRIC_MIN_SECOND_EN
                second     <= nxt_second;
                second_idx <= nxt_second_idx;
`endif
            end
            if (state == HOLD && bus.out_ready) begin
                count    <= '0;
                best     <= BEST_INIT;
                best_idx <= '0;
                found    <= 1'b0;
`ifdef METRIC_MIN_SECOND_EN
                second     <= BEST_INIT;
                second_idx <= '0;
`endif
            end
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = out_valid_c;
    assign bus.out_metric = best;
    assign bus.out_idx    = best_idx;
    assign bus.out_found  = found;
`ifdef METRIC_MIN_SECOND_EN
    assign bus.out_metric2 = second;
    assign bus.out_idx2    = second_idx;
`endif
    assign bus.dbg_state  = state;

endmodule

// File: tb/tb_metric_min_select.sv
// Bench for metric_min_select (NUM_CAND=4). Directed scenarios plus a
// randomized run checked against a selection-based reference model.
module tb_metric_min_select;
  import sd_pkg::*;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam logic [W-1:0] ALL_ONES = 32'hFFFF_FFFF;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [W-1:0] exp_q[$];
  logic [IW:0]  exp_fi_q[$];

  metric_min_select_if #(.WIDTH(W), .NUM_CAND(N)) bus ();

  metric_min_select #(.WIDTH(W), .NUM_CAND(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: collect qualifying arrivals, then pick the smallest
  // and the next smallest by (value, arrival order)
  task automatic ref_model(input logic [W-1:0] ms [N], input logic [W-1:0] r,
                           output logic [W-1:0] m1, output logic [IW-1:0] i1,
                           output logic f, output logic [W-1:0] m2,
                           output logic [IW-1:0] i2);
    int qi[$];
    int b;
    int s;
    for (int i = 0; i < N; i++) if (ms[i] < r) qi.push_back(i);
    f = (qi.size() > 0);
    m1 = ALL_ONES; i1 = '0; m2 = ALL_ONES; i2 = '0;
    b = -1; s = -1;
    foreach (qi[k]) if (b < 0 || ms[qi[k]] < ms[b]) b = qi[k];
    foreach (qi[k]) if (qi[k] != b && (s < 0 || ms[qi[k]] < ms[s])) s = qi[k];
    if (b >= 0) begin m1 = ms[b]; i1 = IW'(b); end
    if (s >= 0) begin m2 = ms[s]; i2 = IW'(s); end
  endtask

  // drivers (all tasks start and end on a falling edge)
  task automatic drive_beat(input logic [W-1:0] m, input logic [W-1:0] r);
    int guard;
    bus.in_valid = 1'b1; bus.in_metric = m; bus.radius = r;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin @(negedge clk); guard++; end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic run_group(input logic [W-1:0] ms [N], input logic [W-1:0] r,
                           input int gap_max, output int lat);
    int g;
    for (int i = 0; i < N; i++) begin
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      repeat (g) @(negedge clk);
      // later beats carry junk radius, which must be ignored
      drive_beat(ms[i], (i == 0) ? r : W'($urandom));
    end
    lat = 0;
    while (!bus.out_valid && lat < 20) begin @(negedge clk); lat++; end
  endtask

  task automatic accept_result();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.dbg_state !== IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", bus.dbg_state, IDLE); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.out_metric !== ALL_ONES) begin errors++; $display("FAIL reset_out_metric got %h want %h", bus.out_metric, ALL_ONES); end
    checks++; if (bus.out_idx !== 2'd0) begin errors++; $display("FAIL reset_out_idx got %0d want 0", bus.out_idx); end
    checks++; if (bus.out_found !== 1'b0) begin errors++; $display("FAIL reset_out_found got %b want 0", bus.out_found); end
  endtask

  task automatic test_basic();
    logic [W-1:0] ms [N];
    int lat;
    ms = '{32'd50, 32'd30, 32'd70, 32'd40};
    run_group(ms, 32'd100, 0, lat);
    checks++; if (lat !== 0) begin errors++; $display("FAIL basic_latency got %0d want 0", lat); end
    checks++; if (bus.out_metric !== 32'd30) begin errors++; $display("FAIL basic_metric got %0d want 30", bus.out_metric); end
    checks++; if (bus.out_idx !== 2'd1) begin errors++; $display("FAIL basic_idx got %0d want 1", bus.out_idx); end
    checks++; if (bus.out_found !== 1'b1) begin errors++; $display("FAIL basic_found got %b want 1", bus.out_found); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL basic_hold_in_ready got %b want 0", bus.in_ready); end
`ifdef METRIC_MIN_SECOND_EN
    checks++; if (bus.out_metric2 !== 32'd40 || bus.out_idx2 !== 2'd3) begin errors++; $display("FAIL basic_second got %0d@%0d want 40@3", bus.out_metric2, bus.out_idx2); end
`endif
    accept_result();
  endtask

  task automatic test_all_pruned();
    logic [W-1:0] ms [N];
    int lat;
    ms = '{32'd50, 32'd30, 32'd20, 32'd40};
    run_group(ms, 32'd20, 0, lat);
    checks++; if (lat !== 0) begin errors++; $display("FAIL pruned_latency got %0d want 0", lat); end
    checks++; if (bus.out_found !== 1'b0) begin errors++; $display("FAIL pruned_found got %b want 0", bus.out_found); end
    checks++; if (bus.out_metric !== ALL_ONES) begin errors++; $display("FAIL pruned_metric got %h want %h", bus.out_metric, ALL_ONES); end
    checks++; if (bus.out_idx !== 2'd0) begin errors++; $display("FAIL pruned_idx got %0d want 0", bus.out_idx); end
    accept_result();
  endtask

  task automatic test_ties();
    logic [W-1:0] ms [N];
    int lat;
    ms = '{32'd25, 32'd10, 32'd10, 32'd25};
    run_group(ms, 32'd100, 0, lat);
    checks++; if (bus.out_metric !== 32'd10 || bus.out_idx !== 2'd1) begin errors++; $display("FAIL ties_best got %0d@%0d want 10@1", bus.out_metric, bus.out_idx); end
`ifdef METRIC_MIN_SECOND_EN
    checks++; if (bus.out_metric2 !== 32'd10 || bus.out_idx2 !== 2'd2) begin errors++; $display("FAIL ties_second got %0d@%0d want 10@2", bus.out_metric2, bus.out_idx2); end
`endif
    accept_result();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] ms [N];
    int lat;
    bit stable;
    ms = '{32'd70, 32'd60, 32'd80, 32'd90};
    run_group(ms, 32'd100, 0, lat);
    checks++; if (bus.out_metric !== 32'd60 || bus.out_idx !== 2'd1) begin errors++; $display("FAIL bp_first got %0d@%0d want 60@1", bus.out_metric, bus.out_idx); end
    stable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_metric !== 32'd60 ||
          bus.out_idx !== 2'd1 || bus.out_found !== 1'b1) stable = 1'b0;
    end
    checks++; if (stable !== 1'b1) begin errors++; $display("FAIL bp_hold_stable got %b want 1", stable); end
    bus.out_ready = 1'b1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_handshake_in_ready got %b want 0", bus.in_ready); end
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++; if (bus.dbg_state !== IDLE || bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got state %0d valid %b want 0/0", bus.dbg_state, bus.out_valid); end
    ms = '{32'd9, 32'd8, 32'd7, 32'd6};
    run_group(ms, 32'd100, 0, lat);
    checks++; if (bus.out_metric !== 32'd6 || bus.out_idx !== 2'd3) begin errors++; $display("FAIL bp_next_group got %0d@%0d want 6@3", bus.out_metric, bus.out_idx); end
`ifdef METRIC_MIN_SECOND_EN
    checks++; if (bus.out_metric2 !== 32'd7 || bus.out_idx2 !== 2'd2) begin errors++; $display("FAIL bp_next_second got %0d@%0d want 7@2", bus.out_metric2, bus.out_idx2); end
`endif
    accept_result();
  endtask

  task automatic test_gaps_radius();
    logic [W-1:0] ms [N];
    int pat [7];
    int k;
    ms = '{32'd60, 32'd90, 32'd10, 32'd80};
    pat = '{1, 0, 0, 1, 1, 0, 1};
    k = 0;
    for (int c = 0; c < 7; c++) begin
      bus.in_valid = (pat[c] == 1);
      bus.in_metric = ms[k];
      bus.radius = (k == 0) ? 32'd100 : 32'd5;
      @(negedge clk);
      if (pat[c] == 1) k++;
    end
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL gaps_latency got valid %b want 1", bus.out_valid); end
    checks++; if (bus.out_metric !== 32'd10 || bus.out_idx !== 2'd2 || bus.out_found !== 1'b1) begin errors++; $display("FAIL gaps_result got %0d@%0d f%b want 10@2 f1", bus.out_metric, bus.out_idx, bus.out_found); end
    accept_result();
  endtask

  task automatic test_reset_mid_group();
    logic [W-1:0] ms [N];
    int lat;
    int results;
    drive_beat(32'd5, 32'd100);
    drive_beat(32'd3, 32'd100);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.dbg_state !== IDLE || bus.out_valid !== 1'b0 || bus.out_metric !== ALL_ONES) begin errors++; $display("FAIL midrst_clear got state %0d valid %b metric %h want 0/0/%h", bus.dbg_state, bus.out_valid, bus.out_metric, ALL_ONES); end
    ms = '{32'd40, 32'd20, 32'd60, 32'd30};
    run_group(ms, 32'd100, 0, lat);
    checks++; if (lat !== 0) begin errors++; $display("FAIL midrst_latency got %0d want 0", lat); end
    checks++; if (bus.out_metric !== 32'd20 || bus.out_idx !== 2'd1) begin errors++; $display("FAIL midrst_result got %0d@%0d want 20@1", bus.out_metric, bus.out_idx); end
    accept_result();
    results = 0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) results++;
    end
    bus.out_ready = 1'b0;
    checks++; if (results !== 0) begin errors++; $display("FAIL midrst_extra_results got %0d want 0", results); end
  endtask

  task automatic test_random();
    logic [W-1:0] ms [N];
    logic [W-1:0] r;
    logic [W-1:0] m1;
    logic [W-1:0] m2;
    logic [IW-1:0] i1;
    logic [IW-1:0] i2;
    logic f;
    logic [W-1:0] em;
    logic [IW:0] efi;
    int lat;
    int mode;
    for (int g = 0; g < 40; g++) begin
      mode = int'($urandom_range(0, 3));
      for (int i = 0; i < N; i++) begin
        case (mode)
          0: ms[i] = W'($urandom_range(0, 15));
          1: ms[i] = W'($urandom_range(0, 255));
          2: ms[i] = W'($urandom);
          default: ms[i] = ($urandom_range(0, 1) == 1) ? ALL_ONES : W'($urandom_range(0, 40));
        endcase
      end
      case (mode)
        0: r = W'($urandom_range(0, 16));
        1: r = W'($urandom_range(0, 300));
        2: r = W'($urandom);
        default: r = ($urandom_range(0, 1) == 1) ? ALL_ONES : W'($urandom_range(0, 40));
      endcase
      ref_model(ms, r, m1, i1, f, m2, i2);
      exp_q.push_back(m1);
      exp_fi_q.push_back({f, i1});
      run_group(ms, r, 2, lat);
      checks++; if (lat !== 0) begin errors++; $display("FAIL rand_latency g%0d got %0d want 0", g, lat); end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      em = exp_q.pop_front();
      efi = exp_fi_q.pop_front();
      checks++;
      if (bus.out_metric !== em || {bus.out_found, bus.out_idx} !== efi) begin
        errors++;
        $display("FAIL rand_result g%0d got %h@%0d f%b want %h@%0d f%b", g, bus.out_metric, bus.out_idx, bus.out_found, em, efi[IW-1:0], efi[IW]);
      end
`ifdef METRIC_MIN_SECOND_EN
      checks++;
      if (bus.out_metric2 !== m2 || bus.out_idx2 !== i2) begin
        errors++;
        $display("FAIL rand_second g%0d got %h@%0d want %h@%0d", g, bus.out_metric2, bus.out_idx2, m2, i2);
      end
`endif
      accept_result();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_metric = '0;
    bus.radius = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_all_pruned();
    test_ties();
    test_backpressure();
    test_gaps_radius();
    test_reset_mid_group();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/metric_min_select.md
Name: metric_min_select

Overview:
- Streaming consumer of the |re|+|im| L1 metrics produced for each constellation candidate in the sphere decoder.
- Accepts NUM_CAND metrics per group over a valid/ready stream, tracks the running minimum against the current sphere radius, and returns the winning metric and candidate index.
- Sits between the metric stage and the tree-search control, which uses the result to pick the next child node or to prune the branch.

Parameters:
- WIDTH, 32, metric and radius width (unsigned, matches metric stage output)
- NUM_CAND, 16, candidates per group (≥2)
- IDX_W, $clog2(NUM_CAND), candidate index width (derived localparam, not overridable)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  metric beat valid
- in_ready  out  1  block can accept a beat
- in_metric  in  WIDTH  unsigned candidate metric
- radius  in  WIDTH  sphere radius; sampled on the first beat of each group
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_metric  out  WIDTH  minimum in-radius metric (all-ones if none found)
- out_idx  out  IDX_W  arrival index (0..NUM_CAND-1) of the winner
- out_found  out  1  at least one metric was strictly below radius

Behaviour:
- FSM states:
  - IDLE: in_ready=1; the first accepted beat goes to ACCUM.
  - ACCUM: in_ready=1; the beat with count==NUM_CAND-1 goes to HOLD.
  - HOLD: in_ready=0, out_valid=1; on out_ready goes to IDLE.
- Reset values: state=IDLE, count=0, best=all-ones, best_idx=0, found=0, out_valid=0, out_metric=all-ones, out_idx=0, out_found=0.
- Beat acceptance: in_valid && in_ready. The index of each beat is the accepted-beat count within the group.
- Radius: on the first beat, rad_q<=radius. Later changes to radius within the group are ignored.
- Qualification: a beat qualifies iff in_metric < rad_q (strict). A metric equal to the radius is pruned.
- Update rule:
  - A beat replaces best iff it qualifies and in_metric < best (strict), so the lowest index wins on ties.
  - found is set on the first qualifying beat.
  - The first beat compares against the reset value of best (all-ones), not against a stale value.
- Latency: out_valid rises the cycle after the last accepted beat. The result includes that last beat.
- Throughput: NUM_CAND+1 cycles per group at best, plus any out_ready stall.
- Holding: out_metric, out_idx and out_found stay stable while out_valid && !out_ready.
- Output handshake cycle: in_ready stays 0 during the out_ready handshake cycle. On the next cycle the FSM is in IDLE and best, found and count are re-initialised.
- No in-radius beat: out_found=0, out_metric=all-ones, out_idx=0.
- Arithmetic: all comparisons unsigned and WIDTH bits. There is no addition, so no overflow is possible.
- Mid-operation reset: rst in any state discards the partial group or held result and restores reset values next edge. No out_valid is produced for the discarded group.
- Gaps: in_valid deasserted mid-group stalls accumulation without loss. The count does not wrap until the group completes.

Optional Feature:
- METRIC_MIN_SECOND_EN, when defined:
  - Adds outputs out_metric2 (WIDTH) and out_idx2 (IDX_W): the second-smallest qualifying metric, used for soft-output LLR.
  - A new strict minimum shifts best into second.
  - Otherwise a qualifying beat with best ≤ m < second replaces second.
  - second resets to all-ones with idx 0, and stays all-ones if fewer than two beats qualify.
- When not defined: the ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Shared package sd_pkg: METRIC_MAX (all-ones WIDTH constant), FSM state enum (IDLE/ACCUM/HOLD), metric width default.
- One sub-module is natural: min_cmp_update. It is combinational and takes best/second/idx, the new metric/idx and rad_q, and returns the next values plus a qualify flag. It is instantiated once.

Test Plan:
- NUM_CAND=4, radius=100, metrics 50,30,70,40 back-to-back → out_valid at cycle 5; out_metric=30, out_idx=1, out_found=1.
- radius=20, metrics 50,30,20,40 → out_found=0, out_metric=0xFFFFFFFF, out_idx=0 (20 equal to radius is pruned).
- Ties: radius=100, metrics 25,10,10,25 → out_idx=1. With METRIC_MIN_SECOND_EN: out_metric2=10, out_idx2=2.
- Backpressure: out_ready=0 for 5 cycles after out_valid → outputs stable, in_ready=0; out_ready=1 → IDLE. A following group 9,8,7,6 yields 6 at idx 3 (no stale best carried over).
- Gaps and radius change: in_valid toggled 1,0,0,1,1,0,1; radius changed from 100 to 5 after the first beat; metrics 60,90,10,80 → radius 100 is used; result 10 at idx 2.
- Reset mid-group: after 2 of 4 beats (5,3), assert rst one cycle, then send 40,20,60,30 → single out_valid with 20 at idx 1; no result for the aborted group.
